// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the memory word address, presents words to decode.
// Latency: first word valid 1 cycle after reset release; redirect to valid in 2 cycles (one bubble); 1 word/cycle sustained.
// Backpressure: InstrReady low holds the presented word by re-reading it; optional FetchCount under IFETCH_COUNT_EN.
module ifetch_seq #(
  parameter int DEPTH    = 8,
  parameter int RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC
`ifdef IFETCH_COUNT_EN
  ,
  output logic [31:0] FetchCount
`endif
);

  localparam int PC_W = $clog2(DEPTH);

  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [PC_W-1:0] addr_pc;
  logic            fire;
  logic            hold_cond;

  // Only the low PC_W bits of the redirect target are meaningful.
  logic [31-PC_W:0] unused_redirect_hi;
  assign unused_redirect_hi = RedirectPC[31:PC_W];

  assign InstrValid = (state_q != FILL);
  assign InstrOut   = Instruction;
  assign InstrPC    = {{(32-PC_W){1'b0}}, rsp_pc_q};
  assign fire       = InstrValid & InstrReady;
  assign hold_cond  = InstrValid & ~InstrReady & ~Redirect;

  // While stalled, re-read the presented word so the registered read data stays stable.
  always_comb begin
    addr_pc = pc_q;
    if (hold_cond) begin
      addr_pc = rsp_pc_q;
    end
  end

  assign Address = {{(32-PC_W){1'b0}}, addr_pc};

  // Next-state and PC update; redirect outranks both stall and accept.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    if (Redirect) begin
      pc_d    = RedirectPC[PC_W-1:0];
      state_d = FILL;
    end else if (state_q == FILL || fire || !InstrValid) begin
      // The read issued this cycle lands next cycle; PC wraps naturally at DEPTH.
      rsp_pc_d = pc_q;
      pc_d     = pc_q + PC_W'(1);
      state_d  = RUN;
    end else begin
      state_d = HOLD;
    end
  end

  // State register; reset discards any in-flight read by returning to FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      pc_q     <= PC_W'(RESET_PC);
      rsp_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
    end
  end

`ifdef IFETCH_COUNT_EN
  // Count words accepted by decode; a word accepted under redirect is squashed and not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchCount <= '0;
    end else if (fire && !Redirect) begin
      FetchCount <= FetchCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq with a 1-cycle registered instruction memory model.
// Memory words[i] = 10*(i+1), DEPTH=8, RESET_PC=0.
// Covers reset, streaming with wrap, stall, redirect (incl. out-of-range and with stall), async reset mid-hold.
module tb_ifetch_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
`ifdef IFETCH_COUNT_EN
  logic [31:0] FetchCount;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:7];
  logic [28:0] unused_addr_hi;
  assign unused_addr_hi = Address[31:3];

  ifetch_seq #(.DEPTH(8), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Address     (Address),
    .Instruction (Instruction),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .InstrOut    (InstrOut),
    .InstrPC     (InstrPC)
`ifdef IFETCH_COUNT_EN
    ,
    .FetchCount  (FetchCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered-read instruction memory.
  always @(posedge clk) begin
    Instruction <= mem[Address[2:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input int idx);
    chk({tag, "_valid"}, {31'd0, InstrValid}, 32'd1);
    chk({tag, "_out"}, InstrOut, 32'(10 * (idx + 1)));
    chk({tag, "_pc"}, InstrPC, 32'(idx));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'(10 * (i + 1));
    rst_n      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'd0;
    InstrReady = 1'b1;

    // Reset state.
    #2;
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_pc", InstrPC, 32'd0);
    chk("rst_addr", Address, 32'd0);

    // Release reset; valid rises after the first posedge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("fill_valid", {31'd0, InstrValid}, 32'd0);
    tick();

    // Stream a full pass plus wrap back to word 0, no bubble.
    for (int i = 0; i < 9; i++) begin
      chk_word("stream", i % 8);
      tick();
    end
    chk_word("post_wrap", 1);
    tick();
    chk_word("at2", 2);

    // Stall three cycles on word 2.
    InstrReady = 1'b0;
    #1;
    chk("stall_addr0", Address, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_word("stall", 2);
      chk("stall_addr", Address, 32'd2);
    end
    InstrReady = 1'b1;
    #1;
    chk("unstall_addr", Address, 32'd3);
    tick();
    chk_word("after_stall", 3);

    // Redirect to 0 while stalled: redirect wins.
    Redirect   = 1'b1;
    RedirectPC = 32'd0;
    InstrReady = 1'b0;
    #1;
    chk("redir_stall_addr", Address, 32'd4);
    tick();
    Redirect   = 1'b0;
    InstrReady = 1'b1;
    chk("redir0_bubble", {31'd0, InstrValid}, 32'd0);
    chk("redir0_addr", Address, 32'd0);
    tick();
    chk_word("redir0_w0", 0);
    tick();
    chk_word("redir0_w1", 1);

    // Redirect to 5 while word 1 is valid.
    Redirect   = 1'b1;
    RedirectPC = 32'd5;
    tick();
    Redirect = 1'b0;
    chk("redir5_bubble", {31'd0, InstrValid}, 32'd0);
    tick();
    chk_word("redir5_w5", 5);
    tick();
    chk_word("redir5_w6", 6);

    // Out-of-range target 13 truncates to 5.
    Redirect   = 1'b1;
    RedirectPC = 32'd13;
    tick();
    Redirect = 1'b0;
    chk("redir13_bubble", {31'd0, InstrValid}, 32'd0);
    tick();
    chk_word("redir13_w5", 5);
    tick();
    chk_word("redir13_w6", 6);
    tick();
    chk_word("redir13_w7", 7);

    // Asynchronous reset in the middle of a hold.
    InstrReady = 1'b0;
    tick();
    chk_word("hold7", 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, InstrValid}, 32'd0);
    chk("arst_pc", InstrPC, 32'd0);
    chk("arst_addr", Address, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    InstrReady = 1'b1;
`ifdef IFETCH_COUNT_EN
    #1;
    chk("cnt_zero", FetchCount, 32'd0);
`endif
    tick();
    for (int i = 0; i < 8; i++) begin
      chk_word("restart", i);
      tick();
    end
`ifdef IFETCH_COUNT_EN
    chk("cnt_pass", FetchCount, 32'd8);
`endif
    chk_word("restart_wrap", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
